// File: rtl/uart_cmd_decoder.sv
// Drains bytes from the UART unload interface, frames sync/addr/data/checksum commands and issues register writes.
// Latency: 3 cycles per byte fetch; wr_en/cmd_err one cycle after the checksum byte is captured.
// Backpressure: none; bytes are pulled only when rx_empty is low, and a bad or stalled frame is dropped with cmd_err.
module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE  = 8'hA5,
    parameter int         DATA_BYTES = 2,
    parameter int         TIMEOUT    = 65535
) (
    input  logic                    rxclk,
    input  logic                    reset,
    input  logic                    rx_empty,
    input  logic [7:0]              rx_data,
    output logic                    uld_rx_data,
    output logic                    wr_en,
    output logic [7:0]              wr_addr,
    output logic [8*DATA_BYTES-1:0] wr_data,
    output logic                    cmd_err,
    output logic                    busy
);

    localparam int          DW        = 8 * DATA_BYTES;
    localparam logic [15:0] L_TIMEOUT = 16'(TIMEOUT);
    localparam logic [2:0]  L_LAST    = 3'(DATA_BYTES - 1);

    typedef enum logic [1:0] {F_IDLE, F_ULD, F_CAP} fetch_t;
    typedef enum logic [1:0] {HUNT, ADDR, DATA, CSUM} frame_t;

    fetch_t          r_fstate, w_fnext;
    frame_t          r_state, w_next;
    logic            r_uld;
    logic            r_wr_en;
    logic            r_cmd_err;
    logic [7:0]      r_wr_addr;
    logic [DW-1:0]   r_wr_data;
    logic [7:0]      r_addr;
    logic [DW-1:0]   r_shift;
    logic [7:0]      r_csum;
    logic [2:0]      r_idx;
    logic [15:0]     r_tcnt;
    logic            w_byte_stb;
    logic            w_tmo;
    logic [DW+7:0]   w_shift_ext;

    assign w_byte_stb  = (r_fstate == F_CAP);
    assign w_tmo       = (TIMEOUT != 0) && (r_state != HUNT) && (r_tcnt == L_TIMEOUT);
    assign w_shift_ext = {r_shift, rx_data};

    // rx_empty is only looked at in F_IDLE so a byte is never unloaded twice
    always_comb begin
        w_fnext = r_fstate;
        case (r_fstate)
            F_IDLE:  if (!rx_empty) w_fnext = F_ULD;
            F_ULD:   w_fnext = F_CAP;
            F_CAP:   w_fnext = F_IDLE;
            default: w_fnext = F_IDLE;
        endcase
    end

    always_comb begin
        w_next = r_state;
        if (w_tmo) begin
            w_next = HUNT;
        end else if (w_byte_stb) begin
            case (r_state)
                HUNT:    if (rx_data == SYNC_BYTE) w_next = ADDR;
                ADDR:    w_next = DATA;
                DATA:    if (r_idx == L_LAST) w_next = CSUM;
                CSUM:    w_next = HUNT;
                default: w_next = HUNT;
            endcase
        end
    end

    always_ff @(posedge rxclk) begin
        if (reset) begin
            r_fstate <= F_IDLE;
            r_state  <= HUNT;
            r_uld    <= 1'b0;
            r_tcnt   <= '0;
        end else begin
            r_fstate <= w_fnext;
            r_state  <= w_next;
            r_uld    <= (w_fnext == F_ULD);
            if (w_byte_stb || w_next == HUNT)
                r_tcnt <= '0;
            else if (r_state != HUNT && r_fstate == F_IDLE)
                r_tcnt <= r_tcnt + 16'd1;
        end
    end

    always_ff @(posedge rxclk) begin
        if (reset) begin
            r_wr_en   <= 1'b0;
            r_cmd_err <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_addr    <= '0;
            r_shift   <= '0;
            r_csum    <= '0;
            r_idx     <= '0;
        end else begin
            r_wr_en   <= 1'b0;
            r_cmd_err <= w_tmo;
            if (w_byte_stb) begin
                case (r_state)
                    HUNT: r_csum <= '0;
                    ADDR: begin
                        r_addr <= rx_data;
                        r_csum <= r_csum + rx_data;
                        r_idx  <= '0;
                    end
                    DATA: begin
                        // first data byte ends up in the MSB position
                        r_shift <= w_shift_ext[DW-1:0];
                        r_csum  <= r_csum + rx_data;
                        r_idx   <= r_idx + 3'd1;
                    end
                    CSUM: begin
                        if (rx_data == r_csum) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_addr;
                            r_wr_data <= r_shift;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign uld_rx_data = r_uld;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign cmd_err     = r_cmd_err;
    assign busy        = (r_state != HUNT);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: UART byte-source model, expected-event scoreboard and decoupled output monitor.
module tb_uart_cmd_decoder;

    logic        rxclk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        uld_rx_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        cmd_err;
    logic        busy;

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] uq[$];
    int         uld_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    uart_cmd_decoder #(.SYNC_BYTE(8'hA5), .DATA_BYTES(2), .TIMEOUT(100)) dut (
        .rxclk       (rxclk),
        .reset       (reset),
        .rx_empty    (rx_empty),
        .rx_data     (rx_data),
        .uld_rx_data (uld_rx_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .cmd_err     (cmd_err),
        .busy        (busy)
    );

    always #5 rxclk = ~rxclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // UART receiver model: an unload pulse seen in one cycle presents the byte the next cycle
    initial begin : uart_model
        bit seen;
        forever begin
            @(negedge rxclk);
            seen = uld_rx_data;
            @(posedge rxclk);
            #1;
            if (seen) begin
                uld_cnt++;
                if (uq.size() != 0) rx_data = uq.pop_front();
            end
            rx_empty = (uq.size() == 0);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge rxclk);
            if (wr_en || cmd_err) begin
                check("wr_en_and_cmd_err_exclusive", {31'd0, wr_en & cmd_err}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {30'd0, wr_en, cmd_err}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_wr_en", {31'd0, wr_en}, {31'd0, e.is_wr});
                    check("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
                    check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic push_bytes(input logic [39:0] f, input int n);
        for (int i = 0; i < n; i++) uq.push_back(f[39-8*i -: 8]);
        @(posedge rxclk);
        #1;
        rx_empty = (uq.size() == 0);
    endtask

    task automatic expect_ev(input bit is_wr, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        e.is_wr = is_wr;
        e.addr  = a;
        e.data  = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while ((uq.size() != 0 || busy) && k < budget) begin
            @(posedge rxclk);
            k++;
        end
        if (k >= budget) check({name, "_timeout"}, 32'(k), 32'(budget - 1));
        repeat (6) @(posedge rxclk);
        #1;
        check({name, "_events_pending"}, 32'(exp_q.size()), 32'd0);
        check({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin : stim
        int u0;
        int k;
        repeat (3) @(posedge rxclk);
        @(negedge rxclk);
        check("reset_uld", {31'd0, uld_rx_data}, 32'd0);
        check("reset_wr_en", {31'd0, wr_en}, 32'd0);
        check("reset_addr_data", {8'd0, wr_addr, wr_data}, 32'd0);
        check("reset_err_busy", {30'd0, cmd_err, busy}, 32'd0);
        @(posedge rxclk);
        #1 reset = 1'b0;

        u0 = uld_cnt;
        expect_ev(1, 8'h12, 16'hBEEF);
        push_bytes(40'hA5_12_BE_EF_BF, 5);
        wait_idle("good_frame", 200);
        check("good_frame_uld_pulses", 32'(uld_cnt - u0), 32'd5);

        expect_ev(0, 8'h12, 16'hBEEF);
        push_bytes(40'hA5_12_BE_EF_00, 5);
        wait_idle("bad_csum", 200);

        expect_ev(1, 8'h01, 16'h0002);
        push_bytes(40'hA5_01_00_02_03, 5);
        wait_idle("after_bad", 200);

        expect_ev(1, 8'h7F, 16'h0001);
        push_bytes(40'h00_FF_A5_7F_00, 5);
        push_bytes(40'h01_80_00_00_00, 2);
        wait_idle("hunting", 200);

        expect_ev(0, 8'h7F, 16'h0001);
        push_bytes(40'hA5_12_00_00_00, 2);
        k = 0;
        while (uq.size() != 0 && k < 50) begin
            @(posedge rxclk);
            k++;
        end
        repeat (4) @(posedge rxclk);
        @(negedge rxclk);
        check("timeout_busy_mid_frame", {31'd0, busy}, 32'd1);
        wait_idle("timeout", 400);

        expect_ev(1, 8'h01, 16'h0002);
        push_bytes(40'hA5_01_00_02_03, 5);
        wait_idle("after_timeout", 200);

        expect_ev(1, 8'hA5, 16'hFFFF);
        push_bytes(40'hA5_A5_FF_FF_A3, 5);
        wait_idle("sync_payload_wrap", 200);

        push_bytes(40'hA5_12_BE_00_00, 3);
        k = 0;
        while (uq.size() != 0 && k < 50) begin
            @(posedge rxclk);
            k++;
        end
        repeat (4) @(posedge rxclk);
        #1 reset = 1'b1;
        @(posedge rxclk);
        #1 reset = 1'b0;
        @(negedge rxclk);
        check("midreset_outputs", {8'd0, wr_addr, wr_data}, 32'd0);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        push_bytes(40'hEF_BF_00_00_00, 2);
        wait_idle("midreset_tail", 200);
        check("midreset_final_outputs", {6'd0, wr_en, cmd_err, wr_addr, wr_data}, 32'd0);
        check("total_uld_pulses", 32'(uld_cnt), 32'd39);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Receive-side command decoder that sits directly downstream of the UART receiver. It drains received bytes from the UART's `rx_data`/`rx_empty`/`uld_rx_data` unload interface and assembles framed register-write commands. It validates each frame with a checksum and issues single-cycle register write strobes to the instrument's control register file. Frames are: sync byte, address byte, `DATA_BYTES` data bytes MSB first, checksum byte.

## Interface
Parameters:
- `SYNC_BYTE`, default 8'hA5: frame start marker.
- `DATA_BYTES`, default 2: data bytes per frame; legal range 1..4.
- `TIMEOUT`, default 65535: maximum idle `rxclk` cycles between bytes inside a frame; 0 disables the timeout. The counter is 16 bits wide.

Ports (single clock `rxclk`; `reset` is synchronous and active-high):
- `rxclk`  in  1  clock; same clock as the UART receiver.
- `reset`  in  1  synchronous, active-high reset.
- `rx_empty`  in  1  from UART; 0 means a received byte is waiting.
- `rx_data`  in  8  from UART; valid the cycle after a `uld_rx_data` pulse.
- `uld_rx_data`  out  1  to UART; one-cycle unload pulse, registered.
- `wr_en`  out  1  one-cycle register-write strobe.
- `wr_addr`  out  8  write address; held until the next `wr_en`.
- `wr_data`  out  8*DATA_BYTES  write data; held until the next `wr_en`.
- `cmd_err`  out  1  one-cycle pulse on a checksum failure or timeout.
- `busy`  out  1  1 whenever the frame FSM is not in HUNT.

## Operation
- **Byte fetch engine** (states F_IDLE, F_ULD, F_CAP):
  - F_IDLE with `rx_empty`=0 -> F_ULD. `uld_rx_data`=1 during F_ULD only.
  - F_ULD -> F_CAP unconditionally.
  - F_CAP: latch `rx_data`, assert the internal `byte_stb` for that cycle, then -> F_IDLE.
  - `rx_empty` is ignored in F_ULD and F_CAP, so a byte is never unloaded twice.
  - Minimum 3 cycles per byte.
- **Frame FSM** (states HUNT, ADDR, DATA, CSUM); it advances only on `byte_stb`:
  - HUNT: byte == `SYNC_BYTE` -> ADDR and clear the checksum. Any other byte is dropped silently, with no `cmd_err`.
  - ADDR: store the address, add it to the checksum -> DATA, data byte index = 0.
  - DATA: shift the byte into the data shift register from the LSB side, so the first byte ends up in the MSB position. Add it to the checksum. After `DATA_BYTES` bytes -> CSUM.
  - CSUM: received byte == checksum -> next cycle `wr_en`=1, `wr_addr`/`wr_data` updated; mismatch -> next cycle `cmd_err`=1, outputs unchanged. Either way -> HUNT.
- **Checksum**: 8-bit sum, modulo 256, of the address and all data bytes. The sync byte is excluded. Carries are discarded.
- **Timeout**:
  - The counter increments each cycle while the FSM is not in HUNT and the fetch engine is in F_IDLE.
  - It clears on `byte_stb` and on entry to HUNT.
  - Count == `TIMEOUT` (and `TIMEOUT` != 0) -> HUNT, with a `cmd_err` pulse the next cycle. The partial frame is discarded.
- A sync-valued byte received in ADDR, DATA or CSUM is treated as payload. There is no resynchronisation mid-frame.
- **Reset**, including reset asserted mid-frame or mid-fetch, drives both FSMs to HUNT/F_IDLE, clears the checksum and timeout counter, and discards any partial frame.
- **Reset values**: `uld_rx_data`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `cmd_err`=0, `busy`=0.

## Timing
- Byte arrival: `rx_empty` is sampled low at the end of cycle T.
  - `uld_rx_data`=1 during T+1.
  - UART `rx_data` is valid during T+2, captured at the end of T+2.
  - `byte_stb` occurs in T+2.
- Checksum byte captured in cycle C -> `wr_en` or `cmd_err` high during C+1 only.
- `wr_addr`/`wr_data` change in the same cycle `wr_en` rises and are stable from then on.
- `busy` rises the cycle after the sync byte's `byte_stb`. It falls the cycle after the CSUM `byte_stb` or after the timeout hit.
- `wr_en` and `cmd_err` are never high in the same cycle.
- Back-to-back frames: the sync byte of the next frame may be fetched while `wr_en` is high. There are no dead cycles.

## Test plan
- **Good frame** (defaults): A5,12,BE,EF,BF -> one `wr_en` pulse with `wr_addr`=12, `wr_data`=BEEF; `cmd_err` stays 0; `uld_rx_data` pulses exactly 5 times.
- **Bad checksum**: A5,12,BE,EF,00 -> `cmd_err` pulses once, no `wr_en`, `wr_addr`/`wr_data` retain their previous values; a following good frame A5,01,00,02,03 -> `wr_en` with `wr_addr`=01, `wr_data`=0002.
- **Hunting**: 00,FF,A5,7F,00,01,80 -> the garbage bytes are dropped without `cmd_err`; `wr_en` with `wr_addr`=7F, `wr_data`=0001.
- **Timeout** (`TIMEOUT`=100): A5,12 then 101 idle cycles -> `cmd_err` pulses once, `busy` returns to 0; a following good frame is accepted.
- **Reset mid-frame**: A5,12,BE, then `reset` for 1 cycle, then EF,BF -> no `wr_en`, no `cmd_err`, all outputs at reset values.
- **Payload contains sync and checksum wrap**: A5,A5,FF,FF,A3 -> `wr_en` with `wr_addr`=A5, `wr_data`=FFFF; the checksum arithmetic is modulo 256, with carries discarded.
